traceback_pk: RTL and testbench

Parametrised successor of the Viterbi traceback unit. It walks the survivor path from a caller-supplied start state for any constraint length K, and keeps only the last ndbps decoded bits unless the block is flagged last. Kept bits are packed LSB-first into OUT_W-bit words. It sits between the survivor-path RAM (read via ph_req/ph, 1-cycle latency) and the descrambler/output stage.

---
 rtl/traceback_pk.sv | 152 +++++++++++++++
 tb/tb_traceback_pk.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traceback_pk.sv
// traceback_pk: Viterbi survivor-path traceback for constraint length K.
// Walks tb_sz decision words backwards from a given start state. It keeps
// either all decoded bits or only the trailing ndbps bits. Kept bits are
// packed LSB-first into OUT_W-bit words.
module traceback_pk #(
    parameter int K     = 7,
    parameter int CNT_W = 10,
    parameter int NDB_W = 8,
    parameter int OUT_W = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [K-2:0]               start_state,
    input  logic [CNT_W-1:0]           tb_sz,
    input  logic [NDB_W-1:0]           ndbps,
    input  logic                       tb_last,
    input  logic [(1<<(K-1))-1:0]      ph,
    output logic                       ph_req,
    output logic                       busy,
    output logic [OUT_W-1:0]           out_bits,
    output logic [$clog2(OUT_W+1)-1:0] out_nbits,
    output logic                       out_valid,
    output logic                       tb_done,
    output logic                       start_err
);

    localparam int SW    = K - 1;
    localparam int NB_W  = $clog2(OUT_W + 1);
    localparam int CMP_W = (CNT_W > NDB_W) ? CNT_W : NDB_W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           fsm;
    logic [SW-1:0]    st;        // current trellis state
    logic [CNT_W-1:0] cnt;       // decisions still to process (index i = cnt-1)
    logic [CNT_W-1:0] req_left;  // decision words still to request
    logic [NDB_W-1:0] ndb_r;
    logic             last_r;
    logic             ph_vld;    // ph carries a requested word this cycle
    logic [OUT_W-1:0] pack;
    logic [NB_W-1:0]  pcnt;

    logic             cur_bit;
    logic             p;
    logic [CMP_W-1:0] idx_x;
    logic [CMP_W-1:0] ndb_x;
    logic             keep;
    logic             last_dec;
    logic [OUT_W-1:0] pack_set;
    logic [NB_W-1:0]  pcnt_set;
    logic             word_full;

    // Decode the current decision and form the pack register after this bit.
    always_comb begin
        cur_bit  = st[SW-1];
        p        = ph[st];
        idx_x    = CMP_W'(cnt - CNT_W'(1));
        ndb_x    = CMP_W'(ndb_r);
        keep     = last_r | (idx_x < ndb_x);
        last_dec = (cnt == CNT_W'(1));
        pack_set = pack;
        for (int j = 0; j < OUT_W; j++) begin
            if (keep && (pcnt == NB_W'(j))) begin
                pack_set[j] = cur_bit;
            end
        end
        pcnt_set  = keep ? (pcnt + NB_W'(1)) : pcnt;
        word_full = (pcnt_set == NB_W'(OUT_W));
    end

    // Control FSM with registered outputs, traceback state and bit packing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm       <= IDLE;
            st        <= '0;
            cnt       <= '0;
            req_left  <= '0;
            ndb_r     <= '0;
            last_r    <= 1'b0;
            ph_vld    <= 1'b0;
            pack      <= '0;
            pcnt      <= '0;
            ph_req    <= 1'b0;
            busy      <= 1'b0;
            out_bits  <= '0;
            out_nbits <= '0;
            out_valid <= 1'b0;
            tb_done   <= 1'b0;
            start_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            tb_done   <= 1'b0;
            start_err <= start & busy;
            ph_vld    <= ph_req;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        st       <= start_state;
                        cnt      <= tb_sz;
                        req_left <= tb_sz;
                        ndb_r    <= ndbps;
                        last_r   <= tb_last;
                        pack     <= '0;
                        pcnt     <= '0;
                        busy     <= 1'b1;
                        if (tb_sz == '0) begin
                            fsm     <= DONE;
                            tb_done <= 1'b1;
                        end else begin
                            fsm    <= RUN;
                            ph_req <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (ph_req) begin
                        req_left <= req_left - CNT_W'(1);
                        ph_req   <= (req_left > CNT_W'(1));
                    end
                    if (ph_vld) begin
                        st  <= {st[SW-2:0], p};
                        cnt <= cnt - CNT_W'(1);
                        // Emit on a full word, or flush a partial word after the last decision.
                        if (word_full || (last_dec && (pcnt_set != '0))) begin
                            out_bits  <= pack_set;
                            out_nbits <= pcnt_set;
                            out_valid <= 1'b1;
                            pack      <= '0;
                            pcnt      <= '0;
                        end else begin
                            pack <= pack_set;
                            pcnt <= pcnt_set;
                        end
                        if (last_dec) begin
                            fsm     <= DONE;
                            tb_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    fsm  <= IDLE;
                    busy <= 1'b0;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traceback_pk.sv
// tb_traceback_pk: directed and randomized traceback runs against a
// behavioural model that walks the trellis with integer arithmetic.
module tb_traceback_pk;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  start_state = '0;
    logic [9:0]  tb_sz = '0;
    logic [7:0]  ndbps = '0;
    logic        tb_last = 1'b0;
    logic [63:0] ph = '0;
    logic        ph_req;
    logic        busy;
    logic [7:0]  out_bits;
    logic [3:0]  out_nbits;
    logic        out_valid;
    logic        tb_done;
    logic        start_err;

    traceback_pk #(.K(7), .CNT_W(10), .NDB_W(8), .OUT_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .start_state(start_state),
        .tb_sz(tb_sz), .ndbps(ndbps), .tb_last(tb_last), .ph(ph),
        .ph_req(ph_req), .busy(busy), .out_bits(out_bits), .out_nbits(out_nbits),
        .out_valid(out_valid), .tb_done(tb_done), .start_err(start_err)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] mem [0:63];
    int          mem_k = 0;
    bit          req_seen = 1'b0;
    logic [7:0]  held_bits = '0;
    logic [3:0]  held_nb = '0;
    int          words_seen = 0;
    logic [7:0]  last_word = '0;
    int          last_nb = 0;
    int          wcyc[$];
    logic [7:0]  wbits[$];
    int          wnb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; serve the decision word requested in the previous cycle.
    task automatic step();
        @(posedge clock);
        #1;
        if (req_seen) begin
            ph = mem[mem_k & 63];
            mem_k++;
        end else begin
            ph = {$urandom, $urandom};
        end
        req_seen = ph_req;
    endtask

    // Reference: walk the trellis, collect kept bits, chunk into words with due cycles.
    task automatic build_expect(input int ss, input int sz, input int nd, input bit last);
        int s;
        int pos;
        int b;
        int pbit;
        logic [7:0] w;
        s = ss;
        pos = 0;
        w = '0;
        wcyc.delete();
        wbits.delete();
        wnb.delete();
        for (int j = 0; j < sz; j++) begin
            b = (s >> 5) & 1;
            pbit = int'(mem[j][s]);
            s = ((s << 1) | pbit) & 63;
            if (last || ((sz - 1 - j) < nd)) begin
                w[pos] = b[0];
                pos++;
                if (pos == 8) begin
                    wcyc.push_back(j + 3);
                    wbits.push_back(w);
                    wnb.push_back(8);
                    w = '0;
                    pos = 0;
                end
            end
        end
        if (pos > 0) begin
            wcyc.push_back(sz + 2);
            wbits.push_back(w);
            wnb.push_back(pos);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ph_req"}, ph_req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_done"}, tb_done, 0);
        chk({tag, "_bits_hold"}, out_bits, held_bits);
        chk({tag, "_nb_hold"}, out_nbits, held_nb);
    endtask

    // pat: 0 all zeros, 1 all ones, 2 random. mode: 0 plain, 1 start mid-run, 2 reset mid-run.
    task automatic run_case(input int ss, input int sz, input int nd, input bit last,
                            input int pat, input int mode, input string tag);
        int  done_n;
        bit  exp_v;
        bit  aborted;
        for (int j = 0; j < 64; j++) begin
            if (pat == 0) mem[j] = '0;
            else if (pat == 1) mem[j] = '1;
            else mem[j] = {$urandom, $urandom};
        end
        build_expect(ss, sz, nd, last);
        done_n = (sz == 0) ? 1 : sz + 2;
        words_seen = 0;
        aborted = 1'b0;
        chk({tag, "_busy_at_start"}, busy, 0);
        start = 1'b1;
        start_state = 6'(ss);
        tb_sz = 10'(sz);
        ndbps = 8'(nd);
        tb_last = last;
        mem_k = 0;
        for (int n = 1; n <= done_n + 1; n++) begin
            step();
            start = 1'b0;
            if (mode == 1 && n == 3) begin
                start = 1'b1;
                start_state = ~6'(ss);
                tb_sz = 10'd5;
                ndbps = 8'd1;
                tb_last = ~last;
            end
            chk({tag, "_ph_req"}, ph_req, (n >= 1 && n <= sz));
            chk({tag, "_busy"}, busy, (n <= done_n));
            chk({tag, "_tb_done"}, tb_done, (n == done_n));
            chk({tag, "_start_err"}, start_err, (mode == 1 && n == 4));
            exp_v = (wcyc.size() > 0) && (wcyc[0] == n);
            chk({tag, "_out_valid"}, out_valid, exp_v);
            if (exp_v) begin
                chk({tag, "_out_bits"}, out_bits, wbits[0]);
                chk({tag, "_out_nbits"}, out_nbits, wnb[0]);
                held_bits = wbits[0];
                held_nb = 4'(wnb[0]);
                last_word = out_bits;
                last_nb = int'(out_nbits);
                words_seen++;
                void'(wcyc.pop_front());
                void'(wbits.pop_front());
                void'(wnb.pop_front());
            end else begin
                chk({tag, "_bits_hold"}, out_bits, held_bits);
                chk({tag, "_nb_hold"}, out_nbits, held_nb);
            end
            if (mode == 2 && n == 4) begin
                #2 reset = 1'b1;
                #1;
                chk({tag, "_rst_ph_req"}, ph_req, 0);
                chk({tag, "_rst_busy"}, busy, 0);
                chk({tag, "_rst_valid"}, out_valid, 0);
                chk({tag, "_rst_done"}, tb_done, 0);
                chk({tag, "_rst_err"}, start_err, 0);
                chk({tag, "_rst_bits"}, out_bits, 0);
                chk({tag, "_rst_nbits"}, out_nbits, 0);
                held_bits = '0;
                held_nb = '0;
                reset = 1'b0;
                req_seen = 1'b0;
                for (int m = 0; m < 3; m++) begin
                    step();
                    check_idle({tag, "_post_rst"});
                end
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) chk({tag, "_words_left"}, wcyc.size(), 0);
    endtask

    initial begin
        // Reset state
        step();
        chk("rst_ph_req", ph_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_tb_done", tb_done, 0);
        chk("rst_start_err", start_err, 0);
        chk("rst_out_bits", out_bits, 0);
        chk("rst_out_nbits", out_nbits, 0);
        reset = 1'b0;
        step();

        // Zero decisions from state 0: two zero words, the second with tb_done
        run_case(0, 16, 16, 1'b0, 0, 0, "zeros16");
        chk("zeros16_nwords", words_seen, 2);
        chk("zeros16_word", last_word, 8'h00);
        chk("zeros16_nb", last_nb, 8);

        // All-ones decisions: states climb to 63, word 0xC0 (back-to-back start)
        run_case(0, 8, 8, 1'b0, 1, 0, "ones8");
        chk("ones8_nwords", words_seen, 1);
        chk("ones8_word", last_word, 8'hC0);
        chk("ones8_nb", last_nb, 8);

        // Only trailing 5 bits kept
        run_case(0, 12, 5, 1'b0, 1, 0, "ones12_nd5");
        chk("ones12_nd5_nwords", words_seen, 1);
        chk("ones12_nd5_word", last_word, 8'h1F);
        chk("ones12_nd5_nb", last_nb, 5);

        // Final block keeps everything: 0xC0/8 then 0x0F/4
        run_case(0, 12, 5, 1'b1, 1, 0, "ones12_last");
        chk("ones12_last_nwords", words_seen, 2);
        chk("ones12_last_word", last_word, 8'h0F);
        chk("ones12_last_nb", last_nb, 4);

        // Start state 0x2A shifted out with zero decisions
        run_case(42, 6, 0, 1'b1, 0, 0, "st2a");
        chk("st2a_word", last_word, 8'h15);
        chk("st2a_nb", last_nb, 6);

        // Empty traceback
        run_case(5, 0, 3, 1'b0, 2, 0, "sz0");
        chk("sz0_nwords", words_seen, 0);

        step();
        check_idle("gap1");

        // Start while busy is ignored and flagged
        run_case(17, 20, 11, 1'b0, 2, 1, "midstart");

        // Reset mid-run, then a clean run
        run_case(33, 15, 15, 1'b1, 2, 2, "midreset");
        run_case(33, 15, 9, 1'b0, 2, 0, "after_reset");

        // Randomized runs, some back-to-back, some separated by idle cycles
        for (int r = 0; r < 12; r++) begin
            run_case($urandom_range(0, 63), $urandom_range(0, 40), $urandom_range(0, 50),
                     1'($urandom_range(0, 1)), 2, 0, "rnd");
            if (r % 3 == 0) begin
                step();
                check_idle("rnd_gap");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
